// File: rtl/alu32_issue_queue.sv
// alu32_issue_queue: FIFO issue stage feeding alu32, with a registered valid/ready result slot.
// Define ALU32_ISSUE_BYPASS_EN to send a command straight to the ALU when the queue is empty.
module alu32_issue_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op,
    input  logic [31:0]   in_a,
    input  logic [31:0]   in_b,
    output logic [31:0]   alu_a,
    output logic [31:0]   alu_b,
    output logic [3:0]    alu_op,
    input  logic [31:0]   alu_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_result,
    output logic [3:0]    out_op,
    output logic [AW:0]   count
);
    logic [3:0]    op_mem [DEPTH];
    logic [31:0]   a_mem  [DEPTH];
    logic [31:0]   b_mem  [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          empty, push, issue, byp, wr, load;
    assign empty    = count == '0;
    assign in_ready = count != (AW+1)'(DEPTH);
    assign push     = in_valid & in_ready;
    assign issue    = !empty & (!out_valid | out_ready);
`ifdef ALU32_ISSUE_BYPASS_EN
    assign byp = empty & in_valid & (!out_valid | out_ready);
`else
    assign byp = 1'b0;
`endif
    assign wr   = push & !byp;
    assign load = issue | byp;
    always_comb begin
        alu_a  = byp ? in_a  : empty ? '0 : a_mem[rd_ptr];
        alu_b  = byp ? in_b  : empty ? '0 : b_mem[rd_ptr];
        alu_op = byp ? in_op : empty ? '0 : op_mem[rd_ptr];
    end
    always_ff @(posedge clk) begin
        if (wr) begin
            op_mem[wr_ptr] <= in_op;
            a_mem[wr_ptr]  <= in_a;
            b_mem[wr_ptr]  <= in_b;
        end
    end
    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_op     <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (issue) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(wr) - (AW+1)'(issue);
            if (load) begin
                out_valid  <= 1'b1;
                out_result <= alu_result;
                out_op     <= alu_op;
            end else if (out_valid & out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu32_issue_queue.sv
// tb_alu32_issue_queue: randomized and directed checks of the issue queue against a queue-based model.
module tb_alu32_issue_queue;
    localparam int DEPTH = 4;
    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } cmd_t;
    logic        clk = 0, reset = 1;
    logic        in_valid = 0, in_ready, out_valid, out_ready = 0;
    logic [3:0]  in_op = 0, alu_op, out_op;
    logic [31:0] in_a = 0, in_b = 0, alu_a, alu_b, alu_result, out_result;
    logic [2:0]  count;
    int          n_chk = 0, n_err = 0;
    cmd_t        q[$];
    logic [31:0] got[$];
    bit          mv = 0, acc;
    logic [31:0] mres = 0;
    logic [3:0]  mop = 0;
    assign alu_result = alu_a + alu_b + {28'b0, alu_op};
    alu32_issue_queue #(.DEPTH(DEPTH), .AW(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_result(alu_result), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_op(out_op), .count(count)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        q.delete();
        mv = 0;
        mres = 0;
        mop = 0;
    endtask
    // One clock: check outputs mid-cycle against the model, then advance the model across the edge.
    task automatic step();
        cmd_t h;
        bit ei, byp, issue;
        @(negedge clk);
        ei = q.size() < DEPTH;
        byp = 0;
`ifdef ALU32_ISSUE_BYPASS_EN
        byp = q.size() == 0 && in_valid && (!mv || out_ready);
`endif
        issue = q.size() != 0 && (!mv || out_ready);
        h = '{op: 4'd0, a: 32'd0, b: 32'd0};
        if (byp) h = '{op: in_op, a: in_a, b: in_b};
        else if (q.size() != 0) h = q[0];
        chk("count", 32'(count), 32'(q.size()));
        chk("in_ready", 32'(in_ready), 32'(ei));
        chk("out_valid", 32'(out_valid), 32'(mv));
        chk("out_result", out_result, mres);
        chk("out_op", 32'(out_op), 32'(mop));
        chk("alu_a", alu_a, h.a);
        chk("alu_b", alu_b, h.b);
        chk("alu_op", 32'(alu_op), 32'(h.op));
        if (mv && out_ready) got.push_back(out_result);
        acc = in_valid && ei;
        if (issue) void'(q.pop_front());
        if (issue || byp) begin
            mres = h.a + h.b + {28'b0, h.op};
            mop = h.op;
            mv = 1;
        end else if (mv && out_ready) mv = 0;
        if (acc && !byp) q.push_back('{op: in_op, a: in_a, b: in_b});
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [3:0] op);
        in_valid = 1;
        in_op = op;
        in_a = 32'h3;
        in_b = 32'h80000001;
    endtask
    initial begin
        int k, cyc;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        model_reset();
        step();
        // single command
        out_ready = 1;
        send(4'd0);
        step();
        in_valid = 0;
`ifdef ALU32_ISSUE_BYPASS_EN
        chk("lat_edge1", 32'(out_valid), 32'd1);
`else
        chk("lat_edge1", 32'(out_valid), 32'd0);
        step();
        chk("lat_edge2", 32'(out_valid), 32'd1);
`endif
        chk("single_res", out_result, 32'h80000004);
        chk("single_op", 32'(out_op), 32'd0);
        step();
        // fill to full with the consumer stalled
        out_ready = 0;
        for (int i = 1; i <= 5; i++) begin
            send(4'(i));
            step();
        end
        send(4'd6);
        step();
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_head_op", 32'(out_op), 32'd1);
        in_valid = 0;
        out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            chk("drain_valid", 32'(out_valid), 32'd1);
            chk("drain_res", out_result, 32'h80000005 + 32'(i));
            chk("drain_op", 32'(out_op), 32'(i + 1));
            step();
        end
        chk("drain_empty", 32'(out_valid), 32'd0);
        // wrap-around streaming with toggling consumer
        got.delete();
        k = 0;
        cyc = 0;
        while (got.size() < 16 && cyc < 200) begin
            if (k < 16) send(4'(k));
            else in_valid = 0;
            out_ready = ~out_ready;
            step();
            if (acc && k < 16) k++;
            cyc++;
        end
        in_valid = 0;
        chk("wrap_total", 32'(got.size()), 32'd16);
        for (int j = 0; j < 16 && j < got.size(); j++) chk("wrap_res", got[j], 32'h80000004 + 32'(j));
        out_ready = 1;
        repeat (3) step();
        // simultaneous push and issue at count 2
        out_ready = 0;
        for (int i = 1; i <= 3; i++) begin
            send(4'(i));
            step();
        end
        in_valid = 0;
        step();
        chk("sim_pre_count", 32'(count), 32'd2);
        out_ready = 1;
        send(4'd4);
        step();
        in_valid = 0;
        out_ready = 0;
        chk("sim_count", 32'(count), 32'd2);
        chk("sim_res", out_result, 32'h80000006);
        chk("sim_op", 32'(out_op), 32'd2);
        step();
        // asynchronous reset mid-cycle with 2 entries queued
        #2 reset = 1;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_result", out_result, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 reset = 0;
        model_reset();
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom);
            in_op = 4'($urandom);
            in_a = $urandom;
            in_b = $urandom;
            out_ready = ($urandom_range(0, 3) != 0) ^ (i >= 200 && i < 260);
            step();
        end
        in_valid = 0;
        out_ready = 1;
        repeat (8) step();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/alu32_issue_queue.md
Name: alu32_issue_queue

Overview:
- Upstream issue stage for alu32: buffers {op, a, b} commands in a FIFO of DEPTH entries.
- Drives the head entry to alu32's operand and op inputs.
- Captures alu32's combinational result into an output register with a valid/ready handshake.
- Decouples the command producer from the result consumer; provides backpressure both ways.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- AW, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  command valid.
- in_ready  output  1  queue can accept a command; equals !full.
- in_op  input  4  ALU op code.
- in_a  input  32  operand A.
- in_b  input  32  operand B.
- alu_a  output  32  to alu32 operand A.
- alu_b  output  32  to alu32 operand B.
- alu_op  output  4  to alu32 op.
- alu_result  input  32  from alu32 result, combinational.
- out_valid  output  1  result register holds data.
- out_ready  input  1  consumer accepts the result.
- out_result  output  32  registered result.
- out_op  output  4  op that produced out_result.
- count  output  AW+1  number of occupied FIFO entries, 0..DEPTH.

Behaviour:
- Reset (async, immediate) clears:
  - rd_ptr, wr_ptr, count, out_valid, out_result, out_op → 0.
  - in_ready reads 1 while and after reset.
- push = in_valid & in_ready:
  - Writes {in_op, in_a, in_b} at wr_ptr.
  - wr_ptr increments modulo DEPTH, wrapping DEPTH-1 → 0.
- Issue (pop) condition: issue = (count != 0) & (!out_valid | out_ready).
- On issue:
  - out_result <= alu_result; out_op <= head op; out_valid <= 1.
  - rd_ptr increments modulo DEPTH.
- Output register drain:
  - out_valid & out_ready & !issue → out_valid <= 0.
  - out_result and out_op hold their last values.
- ALU drive:
  - count != 0: alu_a/alu_b/alu_op = head entry, combinational from the memory read at rd_ptr.
  - count == 0: alu_a, alu_b, alu_op = 0.
- count update:
  - +1 on push only; -1 on issue only.
  - Unchanged on simultaneous push and issue.
- Full (count == DEPTH):
  - in_ready = 0; in_valid is ignored, no overwrite.
  - A push is refused even in a cycle where an issue frees a slot; in_ready is not combinationally dependent on out_ready.
- Empty: no issue; out_valid is controlled only by the drain rule.
- Output stall:
  - out_valid & !out_ready → out_result and out_op hold, no issue.
  - The FIFO keeps filling until full.
- Back-to-back: out_valid & out_ready with count != 0 issues the next entry in the same cycle; sustained throughput is 1 result per clock.
- Latency (bypass off):
  - Command pushed at edge N appears on alu_* after edge N.
  - Result is registered at edge N+1; out_valid is high after edge N+1.
- Ordering: strict FIFO; out_op always matches the op of the command whose result is presented.
- Reset mid-operation: queued commands and any pending result are discarded; no partial output.

Optional Feature:
- Macro: ALU32_ISSUE_BYPASS_EN.
- Defined, bypass applies when count == 0 & in_valid & (!out_valid | out_ready):
  - alu_a/alu_b/alu_op are driven from in_a/in_b/in_op.
  - The result is registered at the same edge as the push, and the FIFO is not written.
  - count stays 0 and in_ready stays 1.
  - Latency is in_valid → out_valid in 1 edge.
- Not defined: every command passes through the FIFO; latency is 2 edges.

Test Plan:
- Bench alu32 stub: alu_result = alu_a + alu_b + {28'b0, alu_op}.
- Reset: assert reset mid-cycle with 2 entries queued → count=0, out_valid=0, out_result=0, in_ready=1 immediately (async).
- Single command: a=32'h00000003, b=32'h80000001, op=4'b0000, out_ready=1 → out_result=32'h80000004, out_op=0.
  - out_valid is high 2 edges after push without the macro, 1 edge with ALU32_ISSUE_BYPASS_EN.
- Fill/full: out_ready=0; push ops 1..5 with a=3, b=32'h80000001.
  - First command lands in the output register; the next DEPTH=4 fill the FIFO, so count=4 and in_ready=0.
  - The 6th push is refused; the queue contents are unchanged.
- Drain order: release out_ready=1 from the full state → results 32'h80000005, 80000006, 80000007, 80000008, 80000009 on consecutive cycles, out_op 1..5 in order, one per clock.
- Wrap-around: stream 16 commands with op=0..15 while out_ready toggles every cycle.
  - All 16 results appear in order, each equal to 32'h80000004+op.
  - No loss or duplication across pointer wrap.
- Simultaneous push/issue at count=2: count stays 2, the new entry is queued behind the existing ones, and out_result takes the head's result.
